// File: rtl/trd_icache.sv
// trd_icache: direct-mapped instruction cache with a word-serial line fill.
// Hits are answered combinationally, including while a fill is running.
// A miss is reported to the core, which replays the fetch later.
// fill_done/fill_trd tell thread control which thread to wake.
module trd_icache #(
  parameter int          LINES      = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_0000,
  parameter logic [31:0] TEXT_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic [2:0]  i_trd,
  output logic [31:0] i_rd_data,
  output logic        i_miss,
  output logic        i_segfault,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data,
  output logic        fill_done,
  output logic [2:0]  fill_trd,
  output logic        busy
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LO    = OFF_W + 2;
  localparam int TAG_W = 32 - LO - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state;
  logic [OFF_W-1:0] beat;
  logic [IDX_W-1:0] fill_idx;
  logic             flush_seen;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      addr_off;
  logic             segv;
  logic             hit;
  logic             miss;
  logic             last_beat;

  assign req_off = i_addr[LO-1:2];
  assign req_idx = i_addr[LO+IDX_W-1:LO];
  assign req_tag = i_addr[31:LO+IDX_W];

  // Subtracting the base folds "below base" into the upper-bound test
  // because an address under the base wraps to a huge offset.
  assign addr_off = i_addr - TEXT_BASE;
  assign segv     = i_rd && ((addr_off >= (TEXT_LIMIT - TEXT_BASE)) || (i_addr[1:0] != 2'b00));

  // The line being refilled is never a hit, even if its old tag still matches.
  assign hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !(busy && (req_idx == fill_idx));
  assign miss = i_rd && !segv && !hit;

  assign i_miss     = miss;
  assign i_segfault = segv;
  assign i_rd_data  = (i_rd && !segv && hit) ? data_mem[req_idx][req_off] : 32'h0;

  assign busy      = (state != IDLE);
  assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));

  // Fill sequencer: latches the missing line, counts beats, pulses fill_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      fill_idx   <= '0;
      fill_trd   <= 3'd0;
      fill_done  <= 1'b0;
      flush_seen <= 1'b0;
      valid      <= '0;
    end else begin
      fill_done <= 1'b0;
      if (flush) valid <= '0;
      case (state)
        IDLE: begin
          if (miss) begin
            state      <= FILL;
            mem_req    <= 1'b1;
            mem_addr   <= {i_addr[31:LO], {LO{1'b0}}};
            fill_idx   <= req_idx;
            fill_trd   <= i_trd;
            beat       <= '0;
            flush_seen <= 1'b0;
          end
        end
        FILL: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              mem_req   <= 1'b0;
              fill_done <= 1'b1;
              state     <= DONE;
              if (!flush && !flush_seen) valid[fill_idx] <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag storage; written only by fill beats, never reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == FILL) && mem_ack) begin
      data_mem[fill_idx][beat] <= mem_rd_data;
      if (last_beat) tag_mem[fill_idx] <= mem_addr[31:LO+IDX_W];
    end
  end

endmodule

// File: tb/tb_trd_icache.sv
// tb_trd_icache: directed bench for trd_icache with hand-computed expectations.
module tb_trd_icache;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_rd;
  logic [2:0]  i_trd;
  logic [31:0] i_rd_data;
  logic        i_miss;
  logic        i_segfault;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rd_data;
  logic        fill_done;
  logic [2:0]  fill_trd;
  logic        busy;

  int checks;
  int failures;

  trd_icache dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rd_data(mem_rd_data), .fill_done(fill_done), .fill_trd(fill_trd), .busy(busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow at the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Probe a fetch for one cycle, then withdraw it before the edge so no fill starts
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [2:0] trd,
                               input logic exp_miss, input logic exp_segv, input logic [31:0] exp_data);
    tick();
    i_rd = 1'b1; i_addr = addr; i_trd = trd;
    #4;
    checkOutput({tag, "_miss"}, 32'(i_miss), 32'(exp_miss));
    checkOutput({tag, "_segv"}, 32'(i_segfault), 32'(exp_segv));
    if (!exp_miss && !exp_segv) checkOutput({tag, "_data"}, i_rd_data, exp_data);
    i_rd = 1'b0;
  endtask

  // Full miss + fill with mem_ack high every beat; data words are d0+k
  task automatic fill_line(input string tag, input logic [31:0] addr, input logic [2:0] trd, input logic [31:0] d0);
    tick();
    i_rd = 1'b1; i_addr = addr; i_trd = trd; mem_ack = 1'b0;
    #4;
    checkOutput({tag, "_miss"}, 32'(i_miss), 32'd1);
    checkOutput({tag, "_req_lo"}, 32'(mem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      i_rd = 1'b0; mem_ack = 1'b1; mem_rd_data = d0 + 32'(k);
      #4;
      checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
      checkOutput({tag, "_maddr"}, mem_addr, addr & 32'hFFFF_FFF0);
      checkOutput({tag, "_nodone"}, 32'(fill_done), 32'd0);
    end
    tick();
    mem_ack = 1'b0;
    #4;
    checkOutput({tag, "_done"}, 32'(fill_done), 32'd1);
    checkOutput({tag, "_ftrd"}, 32'(fill_trd), 32'(trd));
    checkOutput({tag, "_req_end"}, 32'(mem_req), 32'd0);
    tick();
    #4;
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_pulse"}, 32'(fill_done), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_addr = 32'h0; i_rd = 1'b0; i_trd = 3'd0;
    flush = 1'b0; mem_ack = 1'b0; mem_rd_data = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #4;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_maddr", mem_addr, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(fill_done), 32'd0);
    checkOutput("rst_ftrd", 32'(fill_trd), 32'd0);
    checkOutput("rst_miss", 32'(i_miss), 32'd0);
    checkOutput("rst_segv", 32'(i_segfault), 32'd0);

    // 1: cold miss on 0x40, fill_done in the sixth cycle counting the miss cycle
    fill_line("cold", 32'h40, 3'd2, 32'hA0);
    applyStimulus("cold_replay", 32'h44, 3'd2, 1'b0, 1'b0, 32'hA1);

    // 2: hit under fill of 0x80 while line 0x00 is resident
    fill_line("l0", 32'h00, 3'd4, 32'hB0);
    tick();
    i_rd = 1'b1; i_addr = 32'h80; i_trd = 3'd3; mem_ack = 1'b0;
    #4;
    checkOutput("huf_miss", 32'(i_miss), 32'd1);
    tick();
    i_addr = 32'h08; i_trd = 3'd5;
    #4;
    checkOutput("huf_hit", 32'(i_miss), 32'd0);
    checkOutput("huf_data", i_rd_data, 32'hB2);
    checkOutput("huf_busy", 32'(busy), 32'd1);
    tick();
    i_addr = 32'h84;
    #4;
    checkOutput("huf_fillline", 32'(i_miss), 32'd1);
    i_rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ack = 1'b1; mem_rd_data = 32'hC0 + 32'(k);
    end
    tick();
    mem_ack = 1'b0;
    #4;
    checkOutput("huf_done", 32'(fill_done), 32'd1);
    checkOutput("huf_ftrd", 32'(fill_trd), 32'd3);
    tick();
    applyStimulus("huf_after", 32'h84, 3'd5, 1'b0, 1'b0, 32'hC1);

    // 3: conflict at index 0 evicts 0x0000, which then misses again
    fill_line("evict", 32'h100, 3'd1, 32'hD0);
    applyStimulus("evict_hit", 32'h104, 3'd1, 1'b0, 1'b0, 32'hD1);
    applyStimulus("evict_old", 32'h004, 3'd1, 1'b1, 1'b0, 32'h0);
    fill_line("refill", 32'h000, 3'd1, 32'hB0);
    applyStimulus("refill_hit", 32'h00C, 3'd1, 1'b0, 1'b0, 32'hB3);

    // 4: segfaults never start a fill; last legal word is accepted
    applyStimulus("seg_limit", 32'h0001_0000, 3'd0, 1'b0, 1'b1, 32'h0);
    applyStimulus("seg_edge", 32'h0000_FFFC, 3'd0, 1'b1, 1'b0, 32'h0);
    tick();
    i_rd = 1'b1; i_addr = 32'h42;
    #4;
    checkOutput("seg_mis_segv", 32'(i_segfault), 32'd1);
    checkOutput("seg_mis_miss", 32'(i_miss), 32'd0);
    tick();
    i_rd = 1'b0;
    #4;
    checkOutput("seg_noreq", 32'(mem_req), 32'd0);
    checkOutput("seg_nobusy", 32'(busy), 32'd0);

    // 5: flush in IDLE with a concurrent hit, then flush in the middle of a fill
    tick();
    flush = 1'b1; i_rd = 1'b1; i_addr = 32'h44;
    #4;
    checkOutput("flush_oldhit", 32'(i_miss), 32'd0);
    checkOutput("flush_olddata", i_rd_data, 32'hA1);
    i_rd = 1'b0;
    tick();
    flush = 1'b0;
    applyStimulus("flush_gone", 32'h44, 3'd0, 1'b1, 1'b0, 32'h0);
    tick();
    i_rd = 1'b1; i_addr = 32'h40; i_trd = 3'd7;
    for (int k = 0; k < 4; k++) begin
      tick();
      i_rd = 1'b0; mem_ack = 1'b1; mem_rd_data = 32'h50 + 32'(k); flush = (k == 2);
    end
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    #4;
    checkOutput("fmid_done", 32'(fill_done), 32'd1);
    checkOutput("fmid_ftrd", 32'(fill_trd), 32'd7);
    tick();
    fill_line("fmid_again", 32'h40, 3'd6, 32'hE0);
    applyStimulus("fmid_hit", 32'h48, 3'd6, 1'b0, 1'b0, 32'hE2);

    // 6: stall mid-fill of 0x440 (evicting resident 0x40), then reset
    tick();
    i_rd = 1'b1; i_addr = 32'h440; i_trd = 3'd6;
    for (int k = 0; k < 2; k++) begin
      tick();
      i_rd = 1'b0; mem_ack = 1'b1; mem_rd_data = 32'hF0 + 32'(k);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      mem_ack = 1'b0;
      i_rd = (k == 5); i_addr = 32'h40;
      #4;
      checkOutput("stall_maddr", mem_addr, 32'h440);
      checkOutput("stall_req", 32'(mem_req), 32'd1);
      checkOutput("stall_nodone", 32'(fill_done), 32'd0);
      if (k == 5) checkOutput("stall_oldtag_miss", 32'(i_miss), 32'd1);
    end
    tick();
    i_rd = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #4;
    checkOutput("rstmid_req", 32'(mem_req), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    applyStimulus("rstmid_miss", 32'h40, 3'd0, 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
